game_sequencer: RTL and testbench

Top-level game controller that sequences the game engine datapath. Runs the game state machine (idle, spawn, play, hit, over) and schedules physics steps from VGA frame pulses. Gates engine updates, drives the engine's position reset, counts lives, accumulates a BCD score, and formats the quad display word. Sits between the VGA timing generator, the buttons and game_engine.

---
 rtl/game_sequencer.sv | 177 +++++++++++++++++
 tb/tb_game_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game controller: state machine, frame-based physics step scheduling, lives and BCD score.
// Optional pause (i_btn_up toggles PLAY <-> PAUSE) is built when GAME_SEQ_PAUSE_EN is defined.
module game_sequencer #(
    parameter int FRAMES_PER_STEP = 1,
    parameter int LIVES           = 3,
    parameter int RESPAWN_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_frame_start,
    input  logic        i_btn_center,
    input  logic        i_btn_up,
    input  logic        i_is_safe,
    output logic        o_phys_step,
    output logic        o_engine_rst,
    output logic [2:0]  o_state,
    output logic [3:0]  o_lives,
    output logic [15:0] o_score,
    output logic [31:0] o_disp_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_PLAY  = 3'd2,
        ST_HIT   = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  div_reg, div_next;
    logic [9:0]  spawn_reg, spawn_next;
    logic [3:0]  lives_reg, lives_next;
    logic [15:0] score_reg, score_next, score_inc;
    logic        step_reg, step_next;
    logic        engine_rst_reg, engine_rst_next;
    logic        armed_reg, center_q_reg, center_edge;

    // Edges are only honoured once the level registers have sampled real input,
    // so a button held through reset release is not seen as a press.
    assign center_edge = armed_reg & i_btn_center & ~center_q_reg;

`ifdef GAME_SEQ_PAUSE_EN
    logic up_q_reg, up_edge;
    assign up_edge = armed_reg & i_btn_up & ~up_q_reg;
`else
    logic unused_btn_up;
    assign unused_btn_up = i_btn_up;
`endif

    // Saturating 4-digit BCD increment: carry[0] is suppressed at 9999.
    logic [3:0] carry;
    assign carry[0] = (score_reg != 16'h9999);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            logic [3:0] digit;
            assign digit = score_reg[4*gi +: 4];
            assign score_inc[4*gi +: 4] = !carry[gi]        ? digit :
                                          (digit == 4'd9)   ? 4'd0  : digit + 4'd1;
            if (gi < 3) begin : g_carry
                assign carry[gi+1] = carry[gi] & (digit == 4'd9);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg      <= ST_IDLE;
            div_reg        <= 8'd0;
            spawn_reg      <= 10'd0;
            lives_reg      <= 4'd0;
            score_reg      <= 16'd0;
            step_reg       <= 1'b0;
            engine_rst_reg <= 1'b1;
            armed_reg      <= 1'b0;
            center_q_reg   <= 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
            up_q_reg       <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            spawn_reg      <= spawn_next;
            lives_reg      <= lives_next;
            score_reg      <= score_next;
            step_reg       <= step_next;
            engine_rst_reg <= engine_rst_next;
            armed_reg      <= 1'b1;
            center_q_reg   <= i_btn_center;
`ifdef GAME_SEQ_PAUSE_EN
            up_q_reg       <= i_btn_up;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        spawn_next = spawn_reg;
        lives_next = lives_reg;
        score_next = score_reg;
        step_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (center_edge) begin
                    state_next = ST_SPAWN;
                    lives_next = 4'(LIVES);
                    score_next = 16'd0;
                    spawn_next = 10'd0;
                end
            end
            ST_SPAWN: begin
                if (i_frame_start) begin
                    if (spawn_reg == 10'(RESPAWN_FRAMES - 1)) begin
                        state_next = ST_PLAY;
                        div_next   = 8'd0;
                    end else begin
                        spawn_next = spawn_reg + 10'd1;
                    end
                end
            end
            ST_PLAY: begin
`ifdef GAME_SEQ_PAUSE_EN
                if (up_edge) begin
                    state_next = ST_PAUSE;
                end else
`endif
                if (i_frame_start) begin
                    // A collision on a frame takes precedence over any step due that frame.
                    if (!i_is_safe) begin
                        state_next = ST_HIT;
                        lives_next = (lives_reg == 4'd0) ? 4'd0 : lives_reg - 4'd1;
                    end else if (div_reg == 8'(FRAMES_PER_STEP - 1)) begin
                        div_next   = 8'd0;
                        step_next  = 1'b1;
                        score_next = score_inc;
                    end else begin
                        div_next = div_reg + 8'd1;
                    end
                end
            end
            ST_HIT: begin
                if (lives_reg == 4'd0) begin
                    state_next = ST_OVER;
                end else begin
                    state_next = ST_SPAWN;
                    spawn_next = 10'd0;
                end
            end
            ST_OVER: begin
                lives_next = 4'd0;
                if (center_edge) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef GAME_SEQ_PAUSE_EN
            ST_PAUSE: begin
                if (up_edge) begin
                    state_next = ST_PLAY;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
        engine_rst_next = (state_next == ST_IDLE) || (state_next == ST_SPAWN);
    end

    assign o_state      = state_reg;
    assign o_phys_step  = step_reg;
    assign o_engine_rst = engine_rst_reg;
    assign o_lives      = lives_reg;
    assign o_score      = score_reg;
    assign o_disp_data  = {1'b0, state_reg, lives_reg, 8'h00, score_reg};

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a slow instance for the game flow and a
// fast instance (one step per frame) for BCD carry and saturation.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;

    logic        frame, center, up, safe;
    logic        step, engine_rst;
    logic [2:0]  state;
    logic [3:0]  lives;
    logic [15:0] score;
    logic [31:0] disp;

    logic        f_frame, f_center, f_up, f_safe;
    logic        f_step, f_engine_rst;
    logic [2:0]  f_state;
    logic [3:0]  f_lives;
    logic [15:0] f_score;
    logic [31:0] f_disp;

    int n_checks = 0;
    int n_fail   = 0;
    int idle_steps = 0;
    int play_steps = 0;
    int fc = 0;
    int f_steps = 0;
    logic f_last_step;

    always #5 clk = ~clk;

    game_sequencer #(.FRAMES_PER_STEP(3), .LIVES(3), .RESPAWN_FRAMES(4)) dut (
        .clk(clk), .arst_n(arst_n), .i_frame_start(frame), .i_btn_center(center),
        .i_btn_up(up), .i_is_safe(safe), .o_phys_step(step), .o_engine_rst(engine_rst),
        .o_state(state), .o_lives(lives), .o_score(score), .o_disp_data(disp)
    );

    game_sequencer #(.FRAMES_PER_STEP(1), .LIVES(3), .RESPAWN_FRAMES(1)) dut_fast (
        .clk(clk), .arst_n(arst_n), .i_frame_start(f_frame), .i_btn_center(f_center),
        .i_btn_up(f_up), .i_is_safe(f_safe), .o_phys_step(f_step), .o_engine_rst(f_engine_rst),
        .o_state(f_state), .o_lives(f_lives), .o_score(f_score), .o_disp_data(f_disp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic midle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (step) idle_steps++;
        end
    endtask

    task automatic mframe();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic fframe();
        f_frame = 1'b1;
        tick();
        f_frame = 1'b0;
        f_last_step = f_step;
        if (f_step) f_steps++;
        fc++;
        tick();
    endtask

    initial begin
        arst_n = 1'b0;
        frame = 1'b0; center = 1'b1; up = 1'b0; safe = 1'b1;
        f_frame = 1'b0; f_center = 1'b1; f_up = 1'b0; f_safe = 1'b1;
        repeat (3) tick();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_engine_rst", {31'd0, engine_rst}, 32'd1);
        chk("rst_lives", {28'd0, lives}, 32'd0);
        chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_disp", disp, 32'h0);

        // Center held through reset release must not start a game.
        arst_n = 1'b1;
        repeat (3) tick();
        chk("held_center", {29'd0, state}, 32'd0);
        chk("held_center_f", {29'd0, f_state}, 32'd0);
        center = 1'b0; f_center = 1'b0;
        tick();

        center = 1'b1;
        tick();
        center = 1'b0;
        chk("start_state", {29'd0, state}, 32'd1);
        chk("start_lives", {28'd0, lives}, 32'd3);
        chk("start_erst", {31'd0, engine_rst}, 32'd1);
        midle(9);

        for (int k = 1; k <= 4; k++) begin
            mframe();
            chk($sformatf("spawn_state_%0d", k), {29'd0, state}, (k < 4) ? 32'd1 : 32'd2);
            chk($sformatf("spawn_erst_%0d", k), {31'd0, engine_rst}, (k < 4) ? 32'd1 : 32'd0);
            midle(9);
        end
        chk("play_lives", {28'd0, lives}, 32'd3);
        chk("play_score", {16'd0, score}, 32'h0);

        safe = 1'b0;
        midle(5);
        chk("unsafe_noframe", {29'd0, state}, 32'd2);
        safe = 1'b1;

        for (int k = 1; k <= 9; k++) begin
            mframe();
            chk($sformatf("step_f%0d", k), {31'd0, step}, (k % 3 == 0) ? 32'd1 : 32'd0);
            if (step) play_steps++;
            midle(9);
        end
        chk("step_count", play_steps, 32'd3);
        chk("score_3", {16'd0, score}, 32'h0003);
        chk("disp_play", disp, 32'h2300_0003);

        // Two safe frames bring the divider to the step-due point, then a hit.
        mframe(); midle(9);
        mframe(); midle(9);
        safe = 1'b0;
        mframe();
        safe = 1'b1;
        chk("hit_state", {29'd0, state}, 32'd3);
        chk("hit_lives", {28'd0, lives}, 32'd2);
        chk("hit_nostep", {31'd0, step}, 32'd0);
        chk("hit_score", {16'd0, score}, 32'h0003);
        tick();
        chk("hit_to_spawn", {29'd0, state}, 32'd1);
        chk("respawn_erst", {31'd0, engine_rst}, 32'd1);
        center = 1'b1;
        tick();
        center = 1'b0;
        chk("center_in_spawn", {29'd0, state}, 32'd1);
        midle(9);

        for (int h = 1; h <= 2; h++) begin
            for (int k = 0; k < 4; k++) begin
                mframe(); midle(9);
            end
            chk($sformatf("replay_%0d", h), {29'd0, state}, 32'd2);
            safe = 1'b0;
            mframe();
            safe = 1'b1;
            chk($sformatf("hit%0d_lives", h + 1), {28'd0, lives}, 32'(2 - h));
            tick();
            chk($sformatf("after_hit%0d", h + 1), {29'd0, state}, (h == 1) ? 32'd1 : 32'd4);
            midle(9);
        end
        chk("over_disp", disp, 32'h4000_0003);
        chk("stray_steps", idle_steps, 32'd0);

        mframe();
        chk("over_hold", {29'd0, state}, 32'd4);
        center = 1'b1;
        tick();
        center = 1'b0;
        chk("over_to_idle", {29'd0, state}, 32'd0);
        chk("idle_score_kept", {16'd0, score}, 32'h0003);
        tick();
        center = 1'b1;
        tick();
        center = 1'b0;
        chk("restart_state", {29'd0, state}, 32'd1);
        chk("restart_lives", {28'd0, lives}, 32'd3);
        chk("restart_score", {16'd0, score}, 32'h0);

        // Fast instance: one step per frame, drive score through carries to saturation.
        f_center = 1'b1;
        tick();
        f_center = 1'b0;
        chk("f_start", {29'd0, f_state}, 32'd1);
        fframe();
        chk("f_play", {29'd0, f_state}, 32'd2);
        fc = 0;
        while (fc < 9) fframe();
        chk("f_score_0009", {16'd0, f_score}, 32'h0009);
        fframe();
        chk("f_score_0010", {16'd0, f_score}, 32'h0010);
        while (fc < 99) fframe();
        chk("f_score_0099", {16'd0, f_score}, 32'h0099);
        fframe();
        chk("f_score_0100", {16'd0, f_score}, 32'h0100);
        chk("f_step_0100", {31'd0, f_last_step}, 32'd1);
        while (fc < 9999) fframe();
        chk("f_score_9999", {16'd0, f_score}, 32'h9999);
        fframe();
        chk("f_sat_step", {31'd0, f_last_step}, 32'd1);
        chk("f_sat_score", {16'd0, f_score}, 32'h9999);
        chk("f_sat_disp", f_disp, 32'h2300_9999);
        chk("f_step_count", f_steps, 32'd10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
